// File: rtl/tt_crossbar_pkg.sv
`default_nettype none
// ============================================================================
// tt_crossbar_pkg : shared types, constants and address decode helper
// Rev 1.0
// ============================================================================
package tt_crossbar_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Widest address the decode helper accepts; narrower addresses are zero-extended.
   localparam int SEL_ADDR_MAX_W = 64;

   localparam logic [63:0] ERR_RDATA = '0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } slave_state_e;

   function automatic logic [31:0] sel_of(
      input logic [SEL_ADDR_MAX_W-1:0] addr,
      input int                        addr_w,
      input int                        sel_w
   );
      logic [SEL_ADDR_MAX_W-1:0] shifted;
      shifted = addr >> (addr_w - sel_w);
      return 32'(shifted & ((SEL_ADDR_MAX_W'(1) << sel_w) - SEL_ADDR_MAX_W'(1)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tt_rr_arbiter : combinational round-robin pick, first request at/after ptr
// Rev 1.0
// ============================================================================
module tt_rr_arbiter #(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   int               w_sum;
   logic [IDX_W-1:0] w_k;

   // Scan from the farthest offset down so the nearest request to ptr wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      w_sum     = 0;
      w_k       = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_sum = int'(ptr) + i;
         if (w_sum >= N) w_sum = w_sum - N;
         w_k = IDX_W'(w_sum);
         if (req[w_k]) begin
            gnt_valid = 1'b1;
            gnt_idx   = w_k;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tt_crossbar_rr.sv
`default_nettype none
// ============================================================================
// tt_crossbar_rr : N-master x M-slave req/ack crossbar, round-robin per slave
// Rev 1.0
// ============================================================================
module tt_crossbar_rr
   import tt_crossbar_pkg::*;
#(
   parameter int NUM_MASTER = 2,
   parameter int NUM_SLAVE  = 2,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_MASTER-1:0]                master_req,
   input  logic [NUM_MASTER-1:0][ADDR_W-1:0]    master_addr,
   input  logic [NUM_MASTER-1:0]                master_cmd,
   input  logic [NUM_MASTER-1:0][DATA_W-1:0]    master_wdata,
   output logic [NUM_MASTER-1:0]                master_ack,
   output logic [NUM_MASTER-1:0]                master_err,
   output logic [NUM_MASTER-1:0][DATA_W-1:0]    master_rdata,
   output logic [NUM_SLAVE-1:0]                 slave_req,
   output logic [NUM_SLAVE-1:0][ADDR_W-1:0]     slave_addr,
   output logic [NUM_SLAVE-1:0]                 slave_cmd,
   output logic [NUM_SLAVE-1:0][DATA_W-1:0]     slave_wdata,
   input  logic [NUM_SLAVE-1:0]                 slave_ack,
   input  logic [NUM_SLAVE-1:0][DATA_W-1:0]     slave_rdata
);

   localparam int SEL_W  = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;
   localparam int MIDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

   logic [31:0]           w_sel [NUM_MASTER];
   logic [NUM_MASTER-1:0] w_sel_ok;
   logic [NUM_MASTER-1:0] w_owned;
   logic [NUM_MASTER-1:0] w_cand [NUM_SLAVE];
   logic                  w_gnt_valid [NUM_SLAVE];
   logic [MIDX_W-1:0]     w_gnt_idx [NUM_SLAVE];

   slave_state_e          r_state [NUM_SLAVE];
   logic [MIDX_W-1:0]     r_gnt [NUM_SLAVE];
   logic [MIDX_W-1:0]     r_ptr [NUM_SLAVE];
   logic [NUM_MASTER-1:0] r_err_pend;

   always_comb begin
      w_sel    = '{default: '0};
      w_sel_ok = '0;
      for (int m = 0; m < NUM_MASTER; m++) begin
         w_sel[m]    = (NUM_SLAVE == 1) ? 32'd0
                     : sel_of(SEL_ADDR_MAX_W'(master_addr[m]), ADDR_W, SEL_W);
         w_sel_ok[m] = (w_sel[m] < 32'(NUM_SLAVE));
      end
   end

   // A master already holding a slave may not compete anywhere else.
   always_comb begin
      w_owned = '0;
      for (int s = 0; s < NUM_SLAVE; s++)
         if (r_state[s] == S_BUSY) w_owned[r_gnt[s]] = 1'b1;
   end

   always_comb begin
      w_cand = '{default: '0};
      for (int s = 0; s < NUM_SLAVE; s++)
         for (int m = 0; m < NUM_MASTER; m++)
            w_cand[s][m] = master_req[m] && w_sel_ok[m] && !w_owned[m]
                        && (w_sel[m] == 32'(s));
   end

   for (genvar s = 0; s < NUM_SLAVE; s++) begin : g_arb
      tt_rr_arbiter #(.N(NUM_MASTER)) u_arb (
         .req       (w_cand[s]),
         .ptr       (r_ptr[s]),
         .gnt_valid (w_gnt_valid[s]),
         .gnt_idx   (w_gnt_idx[s])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SLAVE; s++) begin
            r_state[s] <= S_IDLE;
            r_gnt[s]   <= '0;
            r_ptr[s]   <= '0;
         end
         r_err_pend <= '0;
      end else begin
         for (int s = 0; s < NUM_SLAVE; s++) begin
            case (r_state[s])
               S_IDLE: begin
                  if (w_gnt_valid[s]) begin
                     r_gnt[s]   <= w_gnt_idx[s];
                     r_state[s] <= S_BUSY;
                  end
               end
               S_BUSY: begin
                  if (slave_ack[s]) begin
                     r_ptr[s]   <= (r_gnt[s] == MIDX_W'(NUM_MASTER - 1)) ? '0
                                 : r_gnt[s] + 1'b1;
                     r_state[s] <= S_IDLE;
                  end
               end
               default: r_state[s] <= S_IDLE;
            endcase
         end
         // Pending flag lives exactly one cycle: it is the error completion itself.
         for (int m = 0; m < NUM_MASTER; m++)
            r_err_pend[m] <= master_req[m] && !w_sel_ok[m] && !r_err_pend[m];
      end
   end

   always_comb begin
      slave_req   = '0;
      slave_addr  = '0;
      slave_cmd   = '0;
      slave_wdata = '0;
      for (int s = 0; s < NUM_SLAVE; s++) begin
         if (r_state[s] == S_BUSY) begin
            slave_req[s]   = master_req[r_gnt[s]];
            slave_addr[s]  = master_addr[r_gnt[s]];
            slave_cmd[s]   = master_cmd[r_gnt[s]];
            slave_wdata[s] = master_wdata[r_gnt[s]];
         end
      end
   end

   always_comb begin
      master_ack   = r_err_pend;
      master_err   = r_err_pend;
      master_rdata = '0;
      for (int m = 0; m < NUM_MASTER; m++)
         if (r_err_pend[m]) master_rdata[m] = DATA_W'(ERR_RDATA);
      for (int s = 0; s < NUM_SLAVE; s++) begin
         if ((r_state[s] == S_BUSY) && slave_ack[s]) begin
            master_ack[r_gnt[s]]   = 1'b1;
            master_rdata[r_gnt[s]] = slave_rdata[s];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tt_crossbar_rr.sv
`default_nettype none
// ============================================================================
// tb_tt_crossbar_rr : directed scoreboard bench for tt_crossbar_rr (2x2 and 2x3)
// Rev 1.0
// ============================================================================
module tb_tt_crossbar_rr;
   import tt_crossbar_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 2 masters x 2 slaves
   logic [1:0]       master_req, master_cmd, master_ack, master_err;
   logic [1:0][31:0] master_addr, master_wdata, master_rdata;
   logic [1:0]       slave_req, slave_cmd, slave_ack;
   logic [1:0][31:0] slave_addr, slave_wdata, slave_rdata;

   // 2 masters x 3 slaves, used for decode-error coverage
   logic [1:0]       d3_master_req, d3_master_cmd, d3_master_ack, d3_master_err;
   logic [1:0][31:0] d3_master_addr, d3_master_wdata, d3_master_rdata;
   logic [2:0]       d3_slave_req, d3_slave_cmd, d3_slave_ack;
   logic [2:0][31:0] d3_slave_addr, d3_slave_wdata, d3_slave_rdata;

   tt_crossbar_rr #(.NUM_MASTER(2), .NUM_SLAVE(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
      .master_wdata(master_wdata), .master_ack(master_ack), .master_err(master_err),
      .master_rdata(master_rdata), .slave_req(slave_req), .slave_addr(slave_addr),
      .slave_cmd(slave_cmd), .slave_wdata(slave_wdata), .slave_ack(slave_ack),
      .slave_rdata(slave_rdata)
   );

   tt_crossbar_rr #(.NUM_MASTER(2), .NUM_SLAVE(3), .ADDR_W(32), .DATA_W(32)) dut3 (
      .clk(clk), .rst(rst),
      .master_req(d3_master_req), .master_addr(d3_master_addr), .master_cmd(d3_master_cmd),
      .master_wdata(d3_master_wdata), .master_ack(d3_master_ack), .master_err(d3_master_err),
      .master_rdata(d3_master_rdata), .slave_req(d3_slave_req), .slave_addr(d3_slave_addr),
      .slave_cmd(d3_slave_cmd), .slave_wdata(d3_slave_wdata), .slave_ack(d3_slave_ack),
      .slave_rdata(d3_slave_rdata)
   );

   typedef struct {
      int          port;   // 0,1 = dut masters; 2,3 = dut3 masters
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic push(input int port, input logic err, input logic [31:0] rdata);
      exp_t e;
      e.port  = port;
      e.err   = err;
      e.rdata = rdata;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
      slave_ack = '0; slave_rdata = '0;
      d3_master_req = '0; d3_master_cmd = '0; d3_master_addr = '0; d3_master_wdata = '0;
      d3_slave_ack = '0; d3_slave_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Response monitor: every master_ack must match the oldest expectation for that port.
   logic [3:0]  mon_ack, mon_err;
   logic [31:0] mon_rd [4];
   int          mon_idx;
   always @(negedge clk) begin
      if (!rst) begin
         mon_ack   = {d3_master_ack, master_ack};
         mon_err   = {d3_master_err, master_err};
         mon_rd[0] = master_rdata[0];
         mon_rd[1] = master_rdata[1];
         mon_rd[2] = d3_master_rdata[0];
         mon_rd[3] = d3_master_rdata[1];
         for (int p = 0; p < 4; p++) begin
            if (mon_ack[p]) begin
               mon_idx = -1;
               foreach (sb_q[i]) if (mon_idx < 0 && sb_q[i].port == p) mon_idx = i;
               if (mon_idx < 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_ack port %0d: got ack=1 required ack=0", p);
               end else begin
                  chk($sformatf("rsp_err[%0d]", p), 64'(mon_err[p]), 64'(sb_q[mon_idx].err));
                  chk($sformatf("rsp_rdata[%0d]", p), 64'(mon_rd[p]), 64'(sb_q[mon_idx].rdata));
                  sb_q.delete(mon_idx);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ea, ew, rd;
      rst = 1'b1;
      clear_inputs();
      do_reset();

      // Reset state
      @(negedge clk);
      chk("reset_slave_req", 64'(slave_req), 64'd0);
      chk("reset_master_ack", 64'({d3_master_ack, master_ack}), 64'd0);
      chk("reset_master_rdata", 64'(master_rdata), 64'd0);
      chk("reset_slave_addr", 64'(slave_addr), 64'd0);
      tick();

      // Single read, slave acks two cycles after slave_req
      master_req[0] = 1'b1; master_addr[0] = 32'h0000_0010; master_cmd[0] = CMD_READ;
      push(0, 1'b0, 32'hA5A5_0001);
      @(negedge clk); chk("t1_slave_req_n", 64'(slave_req), 64'd0);
      tick();
      @(negedge clk);
      chk("t1_slave_req_n1", 64'(slave_req), 64'b01);
      chk("t1_slave_addr", 64'(slave_addr[0]), 64'h10);
      chk("t1_slave_cmd", 64'(slave_cmd[0]), 64'(CMD_READ));
      tick();
      tick();
      slave_ack[0] = 1'b1; slave_rdata[0] = 32'hA5A5_0001;
      @(negedge clk); chk("t1_slave_req_held", 64'(slave_req), 64'b01);
      tick();
      clear_inputs();

      // Contention from reset: alternate M0, M1 on S0 with zero-wait acks
      do_reset();
      master_req = 2'b11; master_cmd = {CMD_WRITE, CMD_WRITE};
      master_addr[0] = 32'h0000_0020; master_wdata[0] = 32'h1111_0000;
      master_addr[1] = 32'h0000_0030; master_wdata[1] = 32'h2222_0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk($sformatf("t2_idle_%0d", k), 64'(slave_req), 64'd0);
         tick();
         ea = (k % 2 == 1) ? 32'h0000_0030 : 32'h0000_0020;
         ew = (k % 2 == 1) ? 32'h2222_0000 : 32'h1111_0000;
         rd = 32'hD000_0000 + 32'(k);
         slave_ack[0] = 1'b1; slave_rdata[0] = rd;
         push(k % 2, 1'b0, rd);
         @(negedge clk);
         chk($sformatf("t2_addr_%0d", k), 64'(slave_addr[0]), 64'(ea));
         chk($sformatf("t2_wdata_%0d", k), 64'(slave_wdata[0]), 64'(ew));
         tick();
         slave_ack = '0; slave_rdata = '0;
      end
      master_req = '0;

      // Parallel paths: M0 -> S0, M1 -> S1 in the same cycle
      master_req = 2'b11; master_cmd = '0;
      master_addr[0] = 32'h0000_0004; master_addr[1] = 32'h8000_0004;
      @(negedge clk); chk("t3_req_cycle", 64'(slave_req), 64'd0);
      tick();
      slave_ack[1] = 1'b1; slave_rdata[1] = 32'hBBBB_0001;
      push(1, 1'b0, 32'hBBBB_0001);
      @(negedge clk);
      chk("t3_both_req", 64'(slave_req), 64'b11);
      chk("t3_s0_addr", 64'(slave_addr[0]), 64'h0000_0004);
      chk("t3_s1_addr", 64'(slave_addr[1]), 64'h8000_0004);
      tick();
      slave_ack = '0; slave_rdata = '0; master_req[1] = 1'b0;
      slave_ack[0] = 1'b1; slave_rdata[0] = 32'hAAAA_0002;
      push(0, 1'b0, 32'hAAAA_0002);
      @(negedge clk); chk("t3_s0_still_busy", 64'(slave_req), 64'b01);
      tick();
      slave_ack = '0; slave_rdata = '0; master_req = '0;

      // Write passthrough on S1
      master_req[1] = 1'b1; master_cmd[1] = CMD_WRITE;
      master_addr[1] = 32'h8000_0100; master_wdata[1] = 32'h1234_5678;
      tick();
      for (int c = 0; c < 2; c++) begin
         if (c == 1) begin
            slave_ack[1] = 1'b1; slave_rdata[1] = 32'hFEED_0000;
            push(1, 1'b0, 32'hFEED_0000);
         end
         @(negedge clk);
         chk($sformatf("t5_req_%0d", c), 64'(slave_req[1]), 64'd1);
         chk($sformatf("t5_cmd_%0d", c), 64'(slave_cmd[1]), 64'(CMD_WRITE));
         chk($sformatf("t5_wdata_%0d", c), 64'(slave_wdata[1]), 64'h1234_5678);
         chk($sformatf("t5_addr_%0d", c), 64'(slave_addr[1]), 64'h8000_0100);
         tick();
      end
      clear_inputs();

      // Reset while S0 is busy with M1 (S0 pointer is 1 here, so M1 wins)
      master_req = 2'b11; master_cmd = '0;
      master_addr[0] = 32'h0000_0050; master_addr[1] = 32'h0000_0040;
      tick();
      rst = 1'b1;
      @(negedge clk); chk("t6_busy_m1", 64'(slave_addr[0]), 64'h0000_0040);
      tick();
      rst = 1'b0; master_req = '0;
      slave_ack[0] = 1'b1; slave_rdata[0] = 32'hDEAD_0000;
      @(negedge clk);
      chk("t6_post_rst_slave_req", 64'(slave_req), 64'd0);
      chk("t6_late_ack_ignored", 64'(master_ack), 64'd0);
      chk("t6_post_rst_rdata", 64'(master_rdata), 64'd0);
      tick();
      slave_ack = '0; slave_rdata = '0; master_req = 2'b11;
      @(negedge clk); chk("t6_rearb_idle", 64'(slave_req), 64'd0);
      tick();
      slave_ack[0] = 1'b1; slave_rdata[0] = 32'h6000_0000;
      push(0, 1'b0, 32'h6000_0000);
      @(negedge clk); chk("t6_ptr0_grants_m0", 64'(slave_addr[0]), 64'h0000_0050);
      tick();
      slave_ack = '0; master_req[0] = 1'b0;
      @(negedge clk); chk("t6_gap", 64'(slave_req), 64'd0);
      tick();
      slave_ack[0] = 1'b1; slave_rdata[0] = 32'h6000_0001;
      push(1, 1'b0, 32'h6000_0001);
      @(negedge clk); chk("t6_then_m1", 64'(slave_addr[0]), 64'h0000_0040);
      tick();
      clear_inputs();

      // Decode error on 3-slave instance: sel=3 errors, sel=2 is valid
      d3_master_req = 2'b11; d3_master_cmd = '0;
      d3_master_addr[0] = 32'h8000_0000; d3_master_addr[1] = 32'hC000_0000;
      push(3, 1'b1, 32'h0000_0000);
      @(negedge clk);
      chk("t4_req_cycle_slave_req", 64'(d3_slave_req), 64'd0);
      chk("t4_req_cycle_ack", 64'(d3_master_ack), 64'd0);
      tick();
      d3_slave_ack[2] = 1'b1; d3_slave_rdata[2] = 32'h3333_0002;
      push(2, 1'b0, 32'h3333_0002);
      @(negedge clk);
      chk("t4_only_s2_req", 64'(d3_slave_req), 64'b100);
      chk("t4_s2_addr", 64'(d3_slave_addr[2]), 64'h8000_0000);
      tick();
      clear_inputs();
      @(negedge clk); chk("t4_no_slave_req_after", 64'(d3_slave_req), 64'd0);

      repeat (2) tick();
      chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
